probe_request_phase: RTL

Downstream neighbour of the hash stage in the probe engine. Pops (value, hash) pairs from the hash stage's show-ahead output FIFO, turns each hash into a bucket address in the hash table and issues a tagged memory read. It parks the probe value in an in-flight buffer indexed by tag. Memory responses may return out of order; each is re-paired with its value and pushed to the compare stage.

---
 rtl/probe_request_phase.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/probe_request_phase.sv
// Probe request phase: pops (value, hash) pairs, issues tagged bucket reads and
// re-pairs out-of-order memory responses with their parked probe values.
module probe_request_phase #(
    parameter int unsigned TAG_W        = 4,
    parameter int unsigned BUCKET_SHIFT = 6
) (
    input  logic             clk,
    input  logic             rst,
    output logic             done,
    input  logic [47:0]      table_base_in,
    input  logic             empty_in,
    output logic             read_en_out,
    input  logic [63:0]      value_in,
    input  logic [63:0]      hash_in,
    output logic             mem_req_valid_out,
    output logic [47:0]      mem_req_addr_out,
    output logic [TAG_W-1:0] mem_req_tag_out,
    input  logic             mem_req_stall_in,
    input  logic             mem_rsp_valid_in,
    input  logic [TAG_W-1:0] mem_rsp_tag_in,
    input  logic [63:0]      mem_rsp_data_in,
    input  logic             afull_in,
    output logic             write_en_out,
    output logic [63:0]      value_out,
    output logic [63:0]      bucket_out
);

    localparam int unsigned NumTags = 2 ** TAG_W;

    typedef enum logic {StInit, StRun} state_e;

    state_e           state_q, state_d;
    logic [TAG_W-1:0] init_cnt_q, init_cnt_d;

    // Free-tag FIFO
    logic [TAG_W-1:0] free_mem_q [NumTags];
    logic [TAG_W-1:0] free_wr_q, free_wr_d;
    logic [TAG_W-1:0] free_rd_q, free_rd_d;
    logic [TAG_W:0]   free_cnt_q, free_cnt_d;

    logic [TAG_W:0]   outstanding_q, outstanding_d;
    logic [63:0]      inflight_q [NumTags];

    logic             req_valid_q, req_valid_d;
    logic [47:0]      req_addr_q, req_addr_d;
    logic [TAG_W-1:0] req_tag_q, req_tag_d;
    logic             wen_q, wen_d;
    logic [63:0]      value_q, value_d;
    logic [63:0]      bucket_q, bucket_d;

    logic             run;
    logic             issue;
    logic             rsp_accept;
    logic             free_push;
    logic [TAG_W-1:0] free_push_tag;
    logic [TAG_W-1:0] issue_tag;

    assign issue_tag = free_mem_q[free_rd_q];

    always_comb begin
        run        = (state_q == StRun);
        // Gated by rst so nothing is popped upstream while the block is being reset.
        issue      = !rst && run && !empty_in && (free_cnt_q != '0) &&
                     !mem_req_stall_in && !afull_in;
        rsp_accept = run && mem_rsp_valid_in;
        free_push  = (state_q == StInit) || rsp_accept;
        free_push_tag = (state_q == StInit) ? init_cnt_q : mem_rsp_tag_in;

        read_en_out = issue;
        done        = !rst && run && empty_in && (outstanding_q == '0) &&
                      !wen_q && !req_valid_q;
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == StInit) begin
            init_cnt_d = init_cnt_q + TAG_W'(1);
            if (init_cnt_q == TAG_W'(NumTags - 1)) begin
                state_d = StRun;
            end
        end

        free_wr_d  = free_push ? free_wr_q + TAG_W'(1) : free_wr_q;
        free_rd_d  = issue ? free_rd_q + TAG_W'(1) : free_rd_q;
        free_cnt_d = free_cnt_q;
        if (free_push && !issue) begin
            free_cnt_d = free_cnt_q + (TAG_W + 1)'(1);
        end else if (!free_push && issue) begin
            free_cnt_d = free_cnt_q - (TAG_W + 1)'(1);
        end

        outstanding_d = outstanding_q;
        if (issue && !rsp_accept) begin
            outstanding_d = outstanding_q + (TAG_W + 1)'(1);
        end else if (!issue && rsp_accept) begin
            outstanding_d = outstanding_q - (TAG_W + 1)'(1);
        end

        req_valid_d = issue;
        req_addr_d  = req_addr_q;
        req_tag_d   = req_tag_q;
        if (issue) begin
            // Truncation to 48 bits gives the modulo-2^48 wrap.
            req_addr_d = 48'({16'd0, table_base_in} + (hash_in << BUCKET_SHIFT));
            req_tag_d  = issue_tag;
        end

        wen_d    = rsp_accept;
        value_d  = value_q;
        bucket_d = bucket_q;
        if (rsp_accept) begin
            value_d  = inflight_q[mem_rsp_tag_in];
            bucket_d = mem_rsp_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StInit;
            init_cnt_q    <= '0;
            free_wr_q     <= '0;
            free_rd_q     <= '0;
            free_cnt_q    <= '0;
            outstanding_q <= '0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            req_tag_q     <= '0;
            wen_q         <= 1'b0;
            value_q       <= '0;
            bucket_q      <= '0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            free_wr_q     <= free_wr_d;
            free_rd_q     <= free_rd_d;
            free_cnt_q    <= free_cnt_d;
            outstanding_q <= outstanding_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            req_tag_q     <= req_tag_d;
            wen_q         <= wen_d;
            value_q       <= value_d;
            bucket_q      <= bucket_d;
        end
    end

    // Storage arrays need no reset: pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (free_push) begin
            free_mem_q[free_wr_q] <= free_push_tag;
        end
        if (issue) begin
            inflight_q[issue_tag] <= value_in;
        end
    end

    assign mem_req_valid_out = req_valid_q;
    assign mem_req_addr_out  = req_addr_q;
    assign mem_req_tag_out   = req_tag_q;
    assign write_en_out      = wen_q;
    assign value_out         = value_q;
    assign bucket_out        = bucket_q;

endmodule
